// File: rtl/prog_delay_line.sv
// Run-time programmable delay line: up to MAX_DELAY register stages with a per-cycle tap select,
// clock-enable stall, flush, and output-valid blanking while a new delay setting propagates.
module prog_delay_line #(
  parameter int WIDTH     = 3,
  parameter int MAX_DELAY = 8,
  parameter int DSEL_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [DSEL_W-1:0] delay_sel,
  input  logic [WIDTH-1:0]  sig_in,
  input  logic              in_valid,
  output logic [WIDTH-1:0]  sig_out,
  output logic              out_valid,
  output logic              settled
);

  // Handshake: there is no backpressure. in_valid qualifies sig_in on every enabled edge, and
  // sig_out is meaningful only while out_valid=1. out_valid is forced low until the current
  // tap has been refilled with samples taken under a stable setting.

  localparam logic [DSEL_W-1:0] MAX_D = DSEL_W'(MAX_DELAY);

  logic [WIDTH-1:0]  s_data [1:MAX_DELAY];
  logic [MAX_DELAY:1] s_valid;
  logic [DSEL_W-1:0] d_eff;
  logic [DSEL_W-1:0] d_q;
  logic [DSEL_W-1:0] cnt;
  logic [WIDTH-1:0]  tap_data;
  logic              tap_valid;

  // Out-of-range requests silently clamp to the deepest stage.
  assign d_eff   = (delay_sel > MAX_D) ? MAX_D : delay_sel;
  assign settled = (d_eff == d_q) && (cnt >= d_eff);

  always_comb begin
    tap_data  = sig_in;
    tap_valid = in_valid;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (d_eff == DSEL_W'(k)) begin
        tap_data  = s_data[k];
        tap_valid = s_valid[k];
      end
    end
  end

  assign sig_out   = tap_data;
  assign out_valid = tap_valid & settled;

  // Flush drops only the valid bits; stale data stays but can never be qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        s_data[k] <= '0;
      end
      s_valid <= '0;
    end else if (flush) begin
      s_valid <= '0;
    end else if (en) begin
      s_data[1]  <= sig_in;
      s_valid[1] <= in_valid;
      for (int k = 2; k <= MAX_DELAY; k++) begin
        s_data[k]  <= s_data[k-1];
        s_valid[k] <= s_valid[k-1];
      end
    end
  end

  // d_q tracks the setting on every edge so a change is seen even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      cnt <= '0;
    end else begin
      d_q <= d_eff;
      if ((d_eff != d_q) || flush) begin
        cnt <= '0;
      end else if (en && (cnt < MAX_D)) begin
        cnt <= cnt + DSEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: a cycle model predicts settled/out_valid/sig_out, which
// are queued when inputs are driven and compared mid-cycle, plus directed reset/bypass checks.
module tb_prog_delay_line;

  localparam int WIDTH     = 3;
  localparam int MAX_DELAY = 8;
  localparam int DSEL_W    = 4;
  localparam int W         = WIDTH + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              flush;
  logic [DSEL_W-1:0] delay_sel;
  logic [WIDTH-1:0]  sig_in;
  logic              in_valid;
  logic [WIDTH-1:0]  sig_out;
  logic              out_valid;
  logic              settled;

  always #5 clk = ~clk;

  prog_delay_line #(
    .WIDTH     (WIDTH),
    .MAX_DELAY (MAX_DELAY),
    .DSEL_W    (DSEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .delay_sel (delay_sel),
    .sig_in    (sig_in),
    .in_valid  (in_valid),
    .sig_out   (sig_out),
    .out_valid (out_valid),
    .settled   (settled)
  );

  int n_checks = 0;
  int n_fail   = 0;
  string phase = "init";
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [WIDTH-1:0] m_data  [1:MAX_DELAY];
  logic             m_valid [1:MAX_DELAY];
  int               m_dq;
  int               m_cnt;

  function automatic int eff(input logic [DSEL_W-1:0] s);
    return (int'(s) > MAX_DELAY) ? MAX_DELAY : int'(s);
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= MAX_DELAY; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_dq  = 0;
    m_cnt = 0;
  endtask

  function automatic logic [W-1:0] model_out();
    int   d;
    logic s;
    d = eff(delay_sel);
    s = (d == m_dq) && (m_cnt >= d);
    if (d == 0) return {s, in_valid & s, sig_in};
    return {s, m_valid[d] & s, m_data[d]};
  endfunction

  task automatic model_edge();
    int d;
    d = eff(delay_sel);
    if (flush) begin
      for (int k = 1; k <= MAX_DELAY; k++) m_valid[k] = 1'b0;
    end else if (en) begin
      for (int k = MAX_DELAY; k >= 2; k--) begin
        m_data[k]  = m_data[k-1];
        m_valid[k] = m_valid[k-1];
      end
      m_data[1]  = sig_in;
      m_valid[1] = in_valid;
    end
    if ((d != m_dq) || flush) m_cnt = 0;
    else if (en && (m_cnt < MAX_DELAY)) m_cnt = m_cnt + 1;
    m_dq = d;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("settled",   8'(settled),   8'(e[W-1]));
    check("out_valid", 8'(out_valid), 8'(e[W-2]));
    check("sig_out",   8'(sig_out),   8'(e[WIDTH-1:0]));
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, then advance the model past the posedge.
  task automatic step(input logic e, input logic f, input logic [DSEL_W-1:0] ds,
                      input logic [WIDTH-1:0] din, input logic v);
    @(negedge clk);
    en        = e;
    flush     = f;
    delay_sel = ds;
    sig_in    = din;
    in_valid  = v;
    exp_q.push_back(model_out());
    #2;
    compare_out();
    model_edge();
  endtask

  task automatic do_reset(input logic [DSEL_W-1:0] ds);
    @(negedge clk);
    rst       = 1'b1;
    en        = 1'b1;
    flush     = 1'b0;
    delay_sel = ds;
    sig_in    = 3'd6;
    in_valid  = 1'b1;
    model_reset();
    exp_q.push_back(model_out());
    #2;
    compare_out();
    check("rst_sig_out",   8'(sig_out),   8'd0);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    @(posedge clk);
    #2;
    exp_q.push_back(model_out());
    compare_out();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    flush     = 1'b0;
    delay_sel = 4'd3;
    sig_in    = '0;
    in_valid  = 1'b0;
    model_reset();

    phase = "reset";
    do_reset(4'd3);

    phase = "t1_d3";
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 4'd3, WIDTH'(i), 1'b1);

    phase = "t2_bypass";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 3'd5, 1'b1);
    @(negedge clk);
    sig_in   = 3'd5;
    in_valid = 1'b1;
    #2;
    check("bypass_data",  8'(sig_out),   8'd5);
    check("bypass_valid", 8'(out_valid), 8'd1);
    in_valid = 1'b0;
    #1;
    check("bypass_vld_lo", 8'(out_valid), 8'd0);
    in_valid = 1'b1;
    #1;
    check("bypass_vld_hi", 8'(out_valid), 8'd1);
    model_edge();

    phase = "t3_stall";
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd4, WIDTH'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 4'd4, WIDTH'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 4'd4, WIDTH'($urandom_range(0, 7)), 1'b1);

    phase = "t4_retap";
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 4'd3, WIDTH'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd5, WIDTH'($urandom_range(0, 7)), 1'b1);

    phase = "t4b_stalled_change";
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'd2, WIDTH'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd2, WIDTH'($urandom_range(0, 7)), 1'b1);

    phase = "t5_flush";
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'd2, WIDTH'($urandom_range(0, 7)), 1'b1);
    step(1'b1, 1'b1, 4'd2, 3'd7, 1'b1);
    step(1'b1, 1'b0, 4'd2, 3'd1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'd2, WIDTH'($urandom_range(0, 7)), 1'b1);

    phase = "t6_clamp";
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 4'd15, WIDTH'($urandom_range(0, 7)), 1'b1);
    @(negedge clk);
    #1;
    check("pre_rst_valid", 8'(out_valid), 8'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_sig_out",   8'(sig_out),   8'd0);
    check("async_rst_out_valid", 8'(out_valid), 8'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;

    phase = "t6_post_rst";
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 4'd15, WIDTH'($urandom_range(0, 7)), 1'b1);

    phase = "end";
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
